// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per cycle with a stored carry.
// Optional macro CHUNKED_SEQ_ADDER_FASTPATH_EN lets DONE hand off straight into RUN on an output transfer.
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [KW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    int               off;
    logic [CHUNK-1:0] a_ch;
    logic [CHUNK-1:0] b_ch;
    logic [CHUNK:0]   chunk_d;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;
    logic             last;
    logic             accept;
    logic             xfer;

    always_comb begin
        off     = int'(k_q) * CHUNK;
        a_ch    = CHUNK'(a_q >> off);
        b_ch    = CHUNK'(b_q >> off);
        chunk_d = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
        // Splice the new chunk into the running sum; untouched chunks keep their value.
        sum_d   = (sum_q & ~(CHUNK_MASK << off)) | (WIDTH'(chunk_d[CHUNK-1:0]) << off);
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (chunk_d[CHUNK-1] != a_q[WIDTH-1]);
        last    = (k_q == K_LAST);
`ifdef CHUNKED_SEQ_ADDER_FASTPATH_EN
        in_ready = ena & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
`else
        in_ready = ena & (state_q == IDLE);
`endif
        accept  = in_valid & in_ready;
        xfer    = out_valid_q & out_ready & ena;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? ~cin : cin;
                        k_q     <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_d[CHUNK];
                    k_q     <= k_q + KW'(1);
                    if (last) begin
                        cout_q      <= chunk_d[CHUNK];
                        ovf_q       <= ovf_d;
                        out_valid_q <= 1'b1;
                        k_q         <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                        // Only reachable with the fast path, where in_ready can be high in DONE.
                        if (accept) begin
                            a_q     <= a;
                            b_q     <= sub ? ~b : b;
                            carry_q <= sub ? ~cin : cin;
                            k_q     <= '0;
                            state_q <= RUN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder (WIDTH=16, CHUNK=4): directed table, corner sequences, random vs integer model.
module tb_chunked_seq_adder;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    chunked_seq_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result for carry/borrow, signed result for overflow.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                  input logic c, output logic [W-1:0] es, output logic ec,
                                  output logic eo);
        int r;
        int sr;
        if (s) begin
            r  = int'(x) - int'(y) - int'(c);
            sr = int'($signed(x)) - int'($signed(y)) - int'(c);
            ec = (r >= 0);
        end else begin
            r  = int'(x) + int'(y) + int'(c);
            sr = int'($signed(x)) + int'($signed(y)) + int'(c);
            ec = (r > 65535);
        end
        es = r[W-1:0];
        eo = (sr > 32767) || (sr < -32768);
    endfunction

    task automatic wait_out(inout int lat);
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_seen", 32'(out_valid), 1);
    endtask

    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                          input logic xc, output logic [W-1:0] rs, output logic rc,
                          output logic ro, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_wait", 32'(in_ready), 1);
        a = xa; b = xb; sub = xs; cin = xc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = 0;
        wait_out(lat);
        rs = sum; rc = cout; ro = ovf;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic         c;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
    } vec_t;

    initial begin
        vec_t         tbl[5];
        logic [W-1:0] rs, es, xa, xb;
        logic         rc, ro, ec, eo, xs, xc;
        int           lat, t1, t2;

        tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        ena = 1'b0; #1;
        chk("ena0_in_ready", 32'(in_ready), 0);
        ena = 1'b1; #1;

        for (int i = 0; i < 5; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, rs, rc, ro, lat);
            chk($sformatf("tbl%0d_sum", i), 32'(rs), 32'(tbl[i].es));
            chk($sformatf("tbl%0d_cout", i), 32'(rc), 32'(tbl[i].ec));
            chk($sformatf("tbl%0d_ovf", i), 32'(ro), 32'(tbl[i].eo));
            chk($sformatf("tbl%0d_latency", i), 32'(lat), 4);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_drop", i), 32'(out_valid), 0);
        end

        // Reset in the middle of RUN; previous result had cout=1, ovf=1.
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("async_sum", 32'(sum), 0);
        chk("async_cout", 32'(cout), 0);
        chk("async_ovf", 32'(ovf), 0);
        chk("async_out_valid", 32'(out_valid), 0);
        chk("async_busy", 32'(busy), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("post_rst_sum", 32'(rs), 32'h2345);
        @(posedge clk); #1;

        // Backpressure with a pending second operation.
        out_ready = 1'b0;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("bp_first_sum", 32'(rs), 32'h3333);
        a = 16'hAAAA; b = 16'h1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_sum_stable", 32'(sum), 32'h3333);
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_out_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
`ifdef CHUNKED_SEQ_ADDER_FASTPATH_EN
        chk("bp_fast_busy", 32'(busy), 1);
`else
        chk("bp_idle_busy", 32'(busy), 0);
        chk("bp_idle_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
`endif
        in_valid = 1'b0;
        lat = 0;
        wait_out(lat);
        chk("bp_second_sum", 32'(sum), 32'hBBBB);
        @(posedge clk); #1;

        // Drop ena for 3 cycles mid-RUN, then verify a frozen DONE does not transfer.
        model(16'h0F0F, 16'h00F1, 1'b1, 1'b1, es, ec, eo);
        a = 16'h0F0F; b = 16'h00F1; sub = 1'b1; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        lat++;
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            lat++;
            chk("ena_busy", 32'(busy), 1);
            chk("ena_out_valid", 32'(out_valid), 0);
        end
        ena = 1'b1;
        wait_out(lat);
        chk("ena_latency", 32'(lat), 7);
        chk("ena_sum", 32'(sum), 32'(es));
        chk("ena_cout", 32'(cout), 32'(ec));
        chk("ena_ovf", 32'(ovf), 32'(eo));
        ena = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("ena_hold_valid", 32'(out_valid), 1);
        ena = 1'b1;
        @(posedge clk); #1;
        chk("ena_xfer_drop", 32'(out_valid), 0);

`ifdef CHUNKED_SEQ_ADDER_FASTPATH_EN
        a = 16'h0001; b = 16'h0001; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'h0002; b = 16'h0002;
        lat = 0;
        wait_out(lat);
        t1 = cyc;
        chk("fast_first_sum", 32'(sum), 32'h0002);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("fast_busy", 32'(busy), 1);
        chk("fast_valid_low", 32'(out_valid), 0);
        lat = 0;
        wait_out(lat);
        t2 = cyc;
        chk("fast_second_sum", 32'(sum), 32'h0004);
        chk("fast_spacing", 32'(t2 - t1), 5);
        @(posedge clk); #1;
`else
        t1 = 0;
        t2 = 0;
`endif

        for (int i = 0; i < 40; i++) begin
            xa = W'($urandom); xb = W'($urandom); xs = 1'($urandom); xc = 1'($urandom);
            if (i < 4) begin
                xa = (i[0]) ? 16'h8000 : 16'h7FFF;
                xb = (i[1]) ? 16'hFFFF : 16'h8000;
            end
            model(xa, xb, xs, xc, es, ec, eo);
            run_op(xa, xb, xs, xc, rs, rc, ro, lat);
            chk($sformatf("rnd%0d_sum", i), 32'(rs), 32'(es));
            chk($sformatf("rnd%0d_cout", i), 32'(rc), 32'(ec));
            chk($sformatf("rnd%0d_ovf", i), 32'(ro), 32'(eo));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 4);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
